// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b.sv
// Programmable 50%-duty clock divider: period 2*(A+1) source cycles, with a shadowed
// divisor that is only applied at period boundaries so the output never glitches.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RN,
   inout  wire          VDD,
   inout  wire          VSS,
   input  logic         EN,
   input  logic [W-1:0] DIV,
   input  logic         LD,
   output logic         Z,
   output logic         ACT,
   output logic         PEND
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN_H = 2'd1,
      RUN_L = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] s_q, s_d;
   logic [W-1:0] c_q, c_d;
   logic         z_q, z_d;
   logic         pend_q, pend_d;

   logic         terminal;
   logic         boundary;

   // Rails carry no logic; folded into a sink so they are not reported as unused.
   logic         unused_rails;
   assign unused_rails = VDD ^ VSS;

   assign terminal = (c_q == a_q);
   assign boundary = (state_q == IDLE) || ((state_q == RUN_L) && terminal);

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
         a_q     <= '0;
         s_q     <= '0;
         c_q     <= '0;
         z_q     <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         s_q     <= s_d;
         c_q     <= c_d;
         z_q     <= z_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      unique case (state_q)
         IDLE: begin
            c_d = '0;
            if (EN) state_d = RUN_H;
         end
         RUN_H: begin
            if (terminal) begin
               state_d = RUN_L;
               c_d     = '0;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         RUN_L: begin
            // EN is only consulted here, so a half-period is never cut short.
            if (terminal) begin
               state_d = EN ? RUN_H : IDLE;
               c_d     = '0;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            c_d     = '0;
         end
      endcase
   end

   always_comb begin
      a_d    = a_q;
      s_d    = s_q;
      pend_d = pend_q;
      if (boundary) begin
         // A fresh load at a boundary bypasses the shadow and takes effect immediately.
         if (LD) begin
            a_d = DIV;
            s_d = DIV;
         end else if (pend_q) begin
            a_d = s_q;
         end
         pend_d = 1'b0;
      end else if (LD) begin
         s_d    = DIV;
         pend_d = 1'b1;
      end
   end

   assign z_d = (state_d == RUN_H);

   always_comb begin
      Z    = z_q;
      ACT  = (state_q != IDLE);
      PEND = pend_q;
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b.sv
// Randomised plus directed bench for the 4-bit clock divider, checked every cycle
// against a period/position model of the output waveform.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b;

   logic       CLK = 1'b0;
   logic       RN  = 1'b1;
   logic       EN  = 1'b0;
   logic       LD  = 1'b0;
   logic [3:0] DIV = 4'd0;
   logic       Z, ACT, PEND;
   wire        VDD = 1'b1;
   wire        VSS = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Reference: run flag, position within the current period, divisor, shadow.
   bit m_run;
   bit m_pend;
   int m_k;
   int m_a;
   int m_s;

   gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b #(.W(4)) dut (
      .CLK  (CLK),
      .RN   (RN),
      .VDD  (VDD),
      .VSS  (VSS),
      .EN   (EN),
      .DIV  (DIV),
      .LD   (LD),
      .Z    (Z),
      .ACT  (ACT),
      .PEND (PEND)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic obs, input logic exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_k    = 0;
      m_a    = 0;
      m_s    = 0;
   endtask

   task automatic model_step();
      int per;
      per = 2 * (m_a + 1);
      if (!m_run || (m_k == per - 1)) begin
         if (LD) begin
            m_a = int'(DIV);
            m_s = int'(DIV);
         end else if (m_pend) begin
            m_a = m_s;
         end
         m_pend = 1'b0;
         m_run  = EN;
         m_k    = 0;
      end else begin
         m_k++;
         if (LD) begin
            m_s    = int'(DIV);
            m_pend = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("Z", Z, m_run && (m_k <= m_a));
      check_eq("ACT", ACT, m_run);
      check_eq("PEND", PEND, m_pend);
   endtask

   task automatic cycle(input logic en, input logic ld, input logic [3:0] div);
      EN  = en;
      LD  = ld;
      DIV = div;
      @(posedge CLK);
      if (RN) model_step();
      #1;
      check_outputs();
   endtask

   // Asserts reset a few time units after an edge, checks it acts at once, holds it.
   task automatic do_async_reset(input int hold);
      #2;
      RN = 1'b0;
      #1;
      model_reset();
      check_outputs();
      for (int i = 0; i < hold; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      #2;
      RN = 1'b1;
   endtask

   task automatic run_until_k(input int target);
      for (int i = 0; i < 64; i++) begin
         if (m_run && (m_k == target)) break;
         cycle(1'b1, 1'b0, 4'd0);
      end
   endtask

   task automatic run_until_last();
      for (int i = 0; i < 64; i++) begin
         if (m_run && (m_k == 2 * (m_a + 1) - 1)) break;
         cycle(1'b1, 1'b0, 4'd0);
      end
   endtask

   initial begin
      logic       en_r, ld_r;
      logic [3:0] div_r;
      model_reset();
      #1;
      RN = 1'b0;
      #1;
      check_outputs();
      cycle(1'b1, 1'b1, 4'd9);
      cycle(1'b1, 1'b0, 4'd0);
      #2;
      RN = 1'b1;

      // Divide by 2 straight out of reset.
      repeat (6) cycle(1'b1, 1'b0, 4'd0);
      repeat (3) cycle(1'b0, 1'b0, 4'd0);

      // Load 3 while idle, then run 4/4.
      cycle(1'b0, 1'b1, 4'd3);
      repeat (17) cycle(1'b1, 1'b0, 4'd0);

      // Mid-high reload to 1: pending until the low-phase terminal edge.
      run_until_k(1);
      cycle(1'b1, 1'b1, 4'd1);
      repeat (14) cycle(1'b1, 1'b0, 4'd0);

      // A=2, drop EN early in the high phase.
      run_until_k(0);
      cycle(1'b1, 1'b1, 4'd2);
      run_until_last();
      cycle(1'b1, 1'b0, 4'd0);
      cycle(1'b0, 1'b0, 4'd0);
      repeat (12) cycle(1'b0, 1'b0, 4'd0);

      // A=5, asynchronous reset mid-high, then divide by 2.
      cycle(1'b0, 1'b1, 4'd5);
      cycle(1'b1, 1'b0, 4'd0);
      run_until_k(2);
      do_async_reset(3);
      repeat (8) cycle(1'b1, 1'b0, 4'd0);

      // Load 15 exactly on the low-phase terminal edge.
      run_until_last();
      cycle(1'b1, 1'b1, 4'd15);
      repeat (34) cycle(1'b1, 1'b0, 4'd0);

      for (int n = 0; n < 3000; n++) begin
         en_r  = ($urandom_range(0, 9) != 0);
         ld_r  = ($urandom_range(0, 7) == 0);
         div_r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         cycle(en_r, ld_r, div_r);
         if ($urandom_range(0, 199) == 0) do_async_reset(int'($urandom_range(1, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
